// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - 8N1 UART receiver that assembles FRAME_BYTES bytes into one word
module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BYTES  = 5,
    parameter int TIMEOUT_CLKS = 4340
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [8*FRAME_BYTES-1:0] data,
    output logic                     recv_done,
    output logic                     frame_err,
    output logic                     timeout,
    output logic [2:0]               sta
);

    localparam int DW = 8 * FRAME_BYTES;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(TIMEOUT_CLKS);
    localparam int CW = $clog2(FRAME_BYTES + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_MID  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [CW-1:0]   byte_q;
    logic [IW-1:0]   idle_q;
    logic [7:0]      shift_q;
    logic [DW-9:0]   asm_q;
    logic [DW-1:0]   data_q;
    logic            recv_done_q;
    logic            frame_err_q;
    logic            timeout_q;

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            idle_q      <= '0;
            shift_q     <= '0;
            asm_q       <= '0;
            data_q      <= '0;
            recv_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            recv_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        baud_q  <= '0;
                        idle_q  <= '0;
                    end else if (byte_q != '0) begin
                        if (idle_q == IDLE_LAST) begin
                            byte_q    <= '0;
                            idle_q    <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (baud_q == BAUD_MID) begin
                        baud_q <= '0;
                        bit_q  <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (rx_s_q) begin
                            // Leave at the stop-bit centre so the next start edge is caught
                            state_q <= S_IDLE;
                            asm_q   <= {asm_q[DW-17:0], shift_q};
                            if (byte_q == BYTE_LAST) begin
                                data_q      <= {asm_q, shift_q};
                                recv_done_q <= 1'b1;
                                byte_q      <= '0;
                            end else begin
                                byte_q <= byte_q + 1'b1;
                            end
                        end else begin
                            state_q     <= S_BREAK;
                            frame_err_q <= 1'b1;
                            byte_q      <= '0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign recv_done = recv_done_q;
    assign frame_err = frame_err_q;
    assign timeout   = timeout_q;
    assign sta       = state_q;

endmodule
